// File: rtl/cpu_fetch_ctrl.sv
// Instruction fetch sequencer: IDLE -> FETCH -> DISPATCH -> EXEC_WAIT, with an optional HALT opcode.
// Define FETCH_HALT_EN to decode ir[15:13] == 3'b111 as HALT; when it is undefined, HALT is unreachable.
module cpu_fetch_ctrl #(
  parameter int                ADDR_W   = 9,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              mem_ready,
  input  logic [15:0]       mem_rdata,
  input  logic              exec_done,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       ir,
  output logic              exec_start,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       instr_count,
  output logic              halted
);

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_READ = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DISPATCH,
    S_EXEC_WAIT,
    S_HALT
  } state_t;

  state_t            r_state;
  logic              r_wait_first;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_ir;
  logic [15:0]       r_count;
  logic              w_halt_op;

`ifdef FETCH_HALT_EN
  assign w_halt_op = (r_ir[15:13] == 3'b111);
  assign halted    = (r_state == S_HALT);
`else
  assign w_halt_op = 1'b0;
  assign halted    = 1'b0;
`endif

  // Moore outputs, decoded from registered state only.
  assign mem_cmd     = (r_state == S_FETCH) ? CMD_READ : CMD_NONE;
  assign mem_addr    = (r_state == S_FETCH) ? r_pc : '0;
  assign exec_start  = (r_state == S_DISPATCH) && !w_halt_op;
  assign ir          = r_ir;
  assign pc          = r_pc;
  assign instr_count = r_count;

  // NOTE: state uses non-blocking assignments so every branch sees this cycle's values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wait_first <= 1'b0;
      r_pc         <= RESET_PC;
      r_ir         <= 16'h0000;
      r_count      <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ready) begin
            r_ir    <= mem_rdata;
            r_pc    <= r_pc + ADDR_W'(1);
            r_state <= S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          if (w_halt_op) begin
            r_state <= S_HALT;
          end else begin
            r_state      <= S_EXEC_WAIT;
            r_wait_first <= 1'b1;
          end
        end
        S_EXEC_WAIT: begin
          // The execute FSM still shows idle in the first cycle after the start pulse.
          r_wait_first <= 1'b0;
          if (!r_wait_first && exec_done) begin
            if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
            r_state <= run ? S_FETCH : S_IDLE;
          end
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
